// File: rtl/shiftreg_univ_pkg.sv
// -----------------------------------------------------------------------------
// shiftreg_pkg
//   Shared definitions for the universal shift register (shiftreg_univ) and
//   its per-stage cell (shiftreg_cell).
//
//   shift_mode_e : operation select applied on every enabled clock edge
//     SR_HOLD      - stages and fill counter keep their value
//     SR_SHIFT_FWD - data moves toward stage DEPTH-1, sin enters stage 0
//     SR_SHIFT_BWD - data moves toward stage 0, sin_r enters stage DEPTH-1
//     SR_LOAD      - every stage takes its slice of the parallel input
// -----------------------------------------------------------------------------
package shiftreg_pkg;

    typedef enum logic [1:0] {
        SR_HOLD      = 2'b00,
        SR_SHIFT_FWD = 2'b01,
        SR_SHIFT_BWD = 2'b10,
        SR_LOAD      = 2'b11
    } shift_mode_e;

endpackage : shiftreg_pkg

// File: rtl/shiftreg_univ_cell.sv
// -----------------------------------------------------------------------------
// shiftreg_cell
//   One WIDTH-bit stage of the universal shift register. The next value is
//   chosen by a 4:1 mux (hold / previous stage / next stage / parallel load)
//   and is only taken on an enabled edge. rst and clr both zero the stage.
//
// Parameters
//   WIDTH        bits held by this stage
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_clr        synchronous clear (same effect as reset)
//   i_en         advance enable; low holds the stage whatever the mode
//   i_mode       operation select
//   i_from_prev  value from the lower-index neighbour (forward shift source)
//   i_from_next  value from the higher-index neighbour (backward shift source)
//   i_load       parallel load value for this stage
//   o_q          registered stage value
// -----------------------------------------------------------------------------
module shiftreg_cell
    import shiftreg_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  shift_mode_e      i_mode,
    input  logic [WIDTH-1:0] i_from_prev,
    input  logic [WIDTH-1:0] i_from_next,
    input  logic [WIDTH-1:0] i_load,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_q;
        case (i_mode)
            SR_HOLD:      w_next = r_q;
            SR_SHIFT_FWD: w_next = i_from_prev;
            SR_SHIFT_BWD: w_next = i_from_next;
            SR_LOAD:      w_next = i_load;
            default:      w_next = r_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule : shiftreg_cell

// File: rtl/shiftreg_univ.sv
// -----------------------------------------------------------------------------
// shiftreg_univ
//   Parametrised universal shift register: DEPTH stages of WIDTH bits with
//   forward shift, backward shift, parallel load and hold, plus a saturating
//   count of stages written since reset/clear. Used as a configurable delay
//   line and as a word serialiser / deserialiser.
//
//   Priority on each edge: rst > clr > en==0 (hold) > mode.
//
// Parameters
//   WIDTH   bits per stage (>= 1)
//   DEPTH   number of stages (>= 2)
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   clr     synchronous clear of all stages and the fill counter
//   en      advance enable; 0 holds everything regardless of mode
//   mode    operation select (shift_mode_e encoding)
//   sin     forward serial input, enters stage 0
//   sin_r   backward serial input, enters stage DEPTH-1
//   pin     parallel load data, stage k = pin[k*WIDTH +: WIDTH]
//   q       stage DEPTH-1 (forward serial output)
//   q_r     stage 0 (backward serial output)
//   pout    all stages, packed like pin
//   fill    stages written since reset/clear, saturating at DEPTH
//   full    fill == DEPTH
//   q_n     ~q, present only when SHIFTREG_UNIV_QN_EN is defined
//
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module shiftreg_univ
    import shiftreg_pkg::*;
#(
    parameter  int unsigned WIDTH = 1,
    parameter  int unsigned DEPTH = 3,
    localparam int unsigned FW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       sin,
    input  logic [WIDTH-1:0]       sin_r,
    input  logic [DEPTH*WIDTH-1:0] pin,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       q_r,
    output logic [DEPTH*WIDTH-1:0] pout,
    output logic [FW-1:0]          fill,
    output logic                   full
`ifdef SHIFTREG_UNIV_QN_EN
    ,
    output logic [WIDTH-1:0]       q_n
`endif
);

    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    shift_mode_e      w_mode;
    logic [WIDTH-1:0] w_stage     [DEPTH];
    logic [WIDTH-1:0] w_from_prev [DEPTH];
    logic [WIDTH-1:0] w_from_next [DEPTH];
    logic [FW-1:0]    r_fill;

    assign w_mode = shift_mode_e'(mode);

    // Stage chain: the serial inputs stand in for the missing neighbour at
    // each end, so every cell sees an identical mux.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_from_prev[k] = sin;
        end else begin : g_mid_prev
            assign w_from_prev[k] = w_stage[k-1];
        end

        if (k == DEPTH - 1) begin : g_last
            assign w_from_next[k] = sin_r;
        end else begin : g_mid_next
            assign w_from_next[k] = w_stage[k+1];
        end

        shiftreg_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_clr       (clr),
            .i_en        (en),
            .i_mode      (w_mode),
            .i_from_prev (w_from_prev[k]),
            .i_from_next (w_from_next[k]),
            .i_load      (pin[k*WIDTH +: WIDTH]),
            .o_q         (w_stage[k])
        );

        assign pout[k*WIDTH +: WIDTH] = w_stage[k];
    end

    // Fill counter: each shift writes one new stage; a load writes all of
    // them. Saturates so long streams keep full asserted.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_fill <= '0;
        end else if (en) begin
            case (w_mode)
                SR_SHIFT_FWD, SR_SHIFT_BWD: begin
                    if (r_fill != FILL_MAX) begin
                        r_fill <= r_fill + 1'b1;
                    end
                end
                SR_LOAD: r_fill <= FILL_MAX;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign q    = w_stage[DEPTH-1];
    assign q_r  = w_stage[0];
    assign fill = r_fill;
    assign full = (r_fill == FILL_MAX);

`ifdef SHIFTREG_UNIV_QN_EN
    assign q_n = ~w_stage[DEPTH-1];
`endif

endmodule : shiftreg_univ
